pmod_gpio_capture: RTL

//  Reverse path of the Pmod GPIO bridging: samples the 8 Pmod header pins (top row + bottom row)
//  as inputs, synchronises and debounces them, and presents the clean value to an AXI GPIO TRI_I

---
 rtl/pmod_capture_pkg.sv | 14 +
 rtl/pmod_capture_debounce.sv | 71 +++++++
 rtl/pmod_gpio_capture.sv | 113 +++++++++++
 3 files changed

// File: rtl/pmod_capture_pkg.sv
// Shared constants for the Pmod GPIO capture path: row/pin widths, bit
// placement of the two header rows, and the tristate values that keep every
// Pmod pin configured as an input.
package pmod_capture_pkg;

    localparam int ROW_W   = 4;
    localparam int PIN_W   = 8;
    localparam int TOP_LSB = 0;
    localparam int BOT_LSB = 4;

    localparam logic [ROW_W-1:0] TRI_T_INPUT = 4'hF;
    localparam logic [ROW_W-1:0] TRI_O_ZERO  = 4'h0;

endpackage

// File: rtl/pmod_capture_debounce.sv
// One-bit capture lane: 2-FF synchroniser followed by an optional debounce
// counter and the accepted (stable) value. rise_o/fall_o are combinational
// strobes that are high in the cycle the stable value is about to change, so
// the parent can update its flags on the same edge as the stable register.
// Optional feature macro: PMOD_CAPTURE_DEBOUNCE_EN (defined -> counter filter,
// undefined -> stable follows the synchroniser every cycle).
module pmod_capture_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin_i,
    output logic stable_o,
    output logic stable_nx_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q;
    logic stable_q, stable_d;

`ifdef PMOD_CAPTURE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept the synced value only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    // No filtering: the stable value tracks the synchroniser output directly.
    always_comb begin
        stable_d = sync2_q;
    end
`endif

    // Synchroniser and stable register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
        end
    end

    assign stable_o    = stable_q;
    assign stable_nx_o = stable_d;
    assign rise_o      = stable_d & ~stable_q;
    assign fall_o      = ~stable_d & stable_q;

endmodule

// File: rtl/pmod_gpio_capture.sv
// Pmod GPIO capture: synchronises/debounces the 8 Pmod pins, drives the clean
// value to AXI GPIO, keeps sticky edge flags with a masked interrupt, and
// emits a 1-deep AXI-Stream change event with a sticky overflow flag.
// Optional feature macro: PMOD_CAPTURE_DEBOUNCE_EN.
module pmod_gpio_capture
    import pmod_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [ROW_W-1:0] pin_top_tri_i,
    input  logic [ROW_W-1:0] pin_bottom_tri_i,
    output logic [ROW_W-1:0] pin_top_tri_t,
    output logic [ROW_W-1:0] pin_top_tri_o,
    output logic [ROW_W-1:0] pin_bottom_tri_t,
    output logic [ROW_W-1:0] pin_bottom_tri_o,
    output logic [PIN_W-1:0] gpio_tri_i,
    output logic [PIN_W-1:0] edge_rise,
    output logic [PIN_W-1:0] edge_fall,
    input  logic [PIN_W-1:0] edge_clr,
    input  logic [PIN_W-1:0] irq_mask,
    output logic             irq,
    output logic [PIN_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             overflow,
    input  logic             overflow_clr
);

    logic [PIN_W-1:0] pin_vec;
    logic [PIN_W-1:0] stable_q, stable_nx, rise_p, fall_p;

    logic [PIN_W-1:0] edge_rise_q, edge_rise_d;
    logic [PIN_W-1:0] edge_fall_q, edge_fall_d;
    logic             irq_q, irq_d;
    logic [PIN_W-1:0] tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             overflow_q, overflow_d;
    logic             change;

    assign pin_vec[TOP_LSB +: ROW_W] = pin_top_tri_i;
    assign pin_vec[BOT_LSB +: ROW_W] = pin_bottom_tri_i;

    for (genvar i = 0; i < PIN_W; i++) begin : g_lane
        pmod_capture_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk        (clk),
            .resetn     (resetn),
            .pin_i      (pin_vec[i]),
            .stable_o   (stable_q[i]),
            .stable_nx_o(stable_nx[i]),
            .rise_o     (rise_p[i]),
            .fall_o     (fall_p[i])
        );
    end

    assign change = |(rise_p | fall_p);

    // Sticky flags (new edge beats clear), irq from the current flags, and the
    // stream holding register that never changes tdata while a beat is pending.
    always_comb begin
        edge_rise_d = (edge_rise_q & ~edge_clr) | rise_p;
        edge_fall_d = (edge_fall_q & ~edge_clr) | fall_p;
        irq_d       = |((edge_rise_q | edge_fall_q) & irq_mask);
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        overflow_d  = overflow_q & ~overflow_clr;
        if (change) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = stable_nx;
                tvalid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // Flag, interrupt and stream registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            edge_rise_q <= '0;
            edge_fall_q <= '0;
            irq_q       <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            edge_rise_q <= edge_rise_d;
            edge_fall_q <= edge_fall_d;
            irq_q       <= irq_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pin_top_tri_t    = TRI_T_INPUT;
    assign pin_top_tri_o    = TRI_O_ZERO;
    assign pin_bottom_tri_t = TRI_T_INPUT;
    assign pin_bottom_tri_o = TRI_O_ZERO;
    assign gpio_tri_i       = stable_q;
    assign edge_rise        = edge_rise_q;
    assign edge_fall        = edge_fall_q;
    assign irq              = irq_q;
    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = tvalid_q;
    assign overflow         = overflow_q;

endmodule
